// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: walks an SRAM operand range two lines at a time,
// adds each pair lane-wise and writes the sums to a result region.
// Ports: clk, rst (sync, active-high); start + read_start_addr,
//   read_end_addr, write_start_addr (run request, latched on accept);
//   busy, done, overflow (status); sram_en, sram_we, sram_addr,
//   sram_wdata, sram_rdata (single SRAM port, 1-cycle read latency).
module calc_seq_ctrl #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [MEM_WORD_SIZE-1:0] sram_wdata,
  input  logic [MEM_WORD_SIZE-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_1,
    S_READ_2,
    S_WAIT,
    S_ADD,
    S_WRITE,
    S_WRITE_WAIT,
    S_END
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_W-1:0]        r_rd_ptr;
  logic [ADDR_W-1:0]        r_end_ptr;
  logic [ADDR_W-1:0]        r_wr_ptr;
  logic [MEM_WORD_SIZE-1:0] r_word_a;
  logic [MEM_WORD_SIZE-1:0] r_word_b;
  logic [MEM_WORD_SIZE-1:0] r_result;
  logic                     r_overflow;

  logic                     w_no_pair;
  logic                     w_last_pair;
  logic [DATA_W:0]          w_sum_lo;
  logic [DATA_W:0]          w_sum_hi;

  // Compares run one bit wider so pointer arithmetic near the top
  // of the address space cannot wrap and fake a remaining pair.
  assign w_no_pair =
    ({1'b0, read_start_addr} + (ADDR_W+1)'(1))
    > {1'b0, read_end_addr};

  assign w_last_pair =
    ({1'b0, r_rd_ptr} + (ADDR_W+1)'(3))
    > {1'b0, r_end_ptr};

  // Independent lanes: the extra MSB is the lane carry-out only.
  assign w_sum_lo =
    {1'b0, r_word_a[DATA_W-1:0]}
    + {1'b0, r_word_b[DATA_W-1:0]};
  assign w_sum_hi =
    {1'b0, r_word_a[MEM_WORD_SIZE-1:DATA_W]}
    + {1'b0, r_word_b[MEM_WORD_SIZE-1:DATA_W]};

  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_end_ptr  <= '0;
      r_wr_ptr   <= '0;
      r_word_a   <= '0;
      r_word_b   <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd_ptr   <= read_start_addr;
            r_end_ptr  <= read_end_addr;
            r_wr_ptr   <= write_start_addr;
            r_overflow <= 1'b0;
          end
        end
        S_READ_2: r_word_a <= sram_rdata;
        S_WAIT:   r_word_b <= sram_rdata;
        S_ADD: begin
          r_result   <= {w_sum_hi[DATA_W-1:0],
                         w_sum_lo[DATA_W-1:0]};
          r_overflow <= r_overflow
                        | w_sum_lo[DATA_W]
                        | w_sum_hi[DATA_W];
        end
        S_WRITE_WAIT: begin
          if (!w_last_pair) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(2);
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_no_pair ? S_END : S_READ_1;
        end
      end
      S_READ_1: begin
        sram_en   = 1'b1;
        sram_addr = r_rd_ptr;
        w_next    = S_READ_2;
      end
      S_READ_2: begin
        sram_en   = 1'b1;
        sram_addr = r_rd_ptr + ADDR_W'(1);
        w_next    = S_WAIT;
      end
      S_WAIT: w_next = S_ADD;
      S_ADD:  w_next = S_WRITE;
      S_WRITE: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = r_wr_ptr;
        sram_wdata = r_result;
        w_next     = S_WRITE_WAIT;
      end
      S_WRITE_WAIT: begin
        w_next = w_last_pair ? S_END : S_READ_1;
      end
      S_END: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: drives runs of calc_seq_ctrl against a behavioural
// SRAM and checks write traffic, timing and status with a scoreboard.
module tb_calc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  read_start_addr;
  logic [8:0]  read_end_addr;
  logic [8:0]  write_start_addr;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        sram_en;
  logic        sram_we;
  logic [8:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;

  logic [63:0] mem [512];
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [63:0] ld_data;

  logic [8:0]  q_addr [$];
  logic [63:0] q_data [$];

  int n_chk;
  int n_err;

  calc_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .read_start_addr  (read_start_addr),
    .read_end_addr    (read_end_addr),
    .write_start_addr (write_start_addr),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .sram_en          (sram_en),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a,
                      input logic [63:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic run(input logic [8:0] rs,
                     input logic [8:0] re,
                     input logic [8:0] ws,
                     input int         rst_at,
                     input bit         poke_start);
    int          n_pairs;
    int          exp_done;
    int          k;
    int          nrd;
    bit          got;
    logic        ov;
    logic [8:0]  wa;
    logic [8:0]  ia;
    logic [63:0] a;
    logic [63:0] b;
    logic [32:0] lo;
    logic [32:0] hi;
    if (int'(rs) + 1 > int'(re)) n_pairs = 0;
    else n_pairs = (int'(re) - int'(rs) + 1) / 2;
    exp_done = (n_pairs == 0) ? 1 : 6 * n_pairs + 1;
    ov = 1'b0;
    wa = ws;
    for (int p = 0; p < n_pairs; p++) begin
      ia = rs + 9'(2 * p);
      a  = mem[ia];
      ia = ia + 9'd1;
      b  = mem[ia];
      lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      hi = {1'b0, a[63:32]} + {1'b0, b[63:32]};
      ov = ov | lo[32] | hi[32];
      if (rst_at == 0) begin
        q_addr.push_back(wa);
        q_data.push_back({hi[31:0], lo[31:0]});
      end
      wa = wa + 9'd1;
    end
    @(negedge clk);
    read_start_addr  = rs;
    read_end_addr    = re;
    write_start_addr = ws;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k   = 0;
    nrd = 0;
    got = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (rst_at > 0 && c > rst_at) begin
        check("rst_en", sram_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_ovf", overflow, 0);
        if (c >= rst_at + 8) break;
      end else begin
        if (sram_en && !sram_we) begin
          nrd++;
          check("rd_range",
                (int'(sram_addr) >= int'(rs)) &&
                (int'(sram_addr) < int'(rs) + 2 * n_pairs),
                1);
        end
        if (sram_en && sram_we) begin
          if (q_addr.size() == 0) begin
            check("wr_extra", 1, 0);
          end else begin
            check("wr_addr", sram_addr, q_addr.pop_front());
            check("wr_data", sram_wdata, q_data.pop_front());
            check("wr_cyc", c, 6 * k + 5);
          end
          k++;
        end
        if (done) begin
          check("done_cyc", c, exp_done);
          check("busy_end", busy, 1);
          got = 1'b1;
          break;
        end
      end
      start = poke_start && (c == 3 || c == 8);
      if (start) begin
        read_start_addr  = 9'd100;
        read_end_addr    = 9'd300;
        write_start_addr = 9'd200;
      end
      if (rst_at == c) rst = 1'b1;
      else if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (rst_at == 0) begin
      if (!got) check("done_timeout", 0, 1);
      check("n_reads", nrd, 2 * n_pairs);
      check("q_empty", q_addr.size(), 0);
      check("ovf_end", overflow, ov);
      @(negedge clk);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      check("ovf_hold", overflow, ov);
    end else begin
      rst = 1'b0;
      q_addr.delete();
      q_data.delete();
    end
  endtask

  initial begin
    n_chk            = 0;
    n_err            = 0;
    rst              = 1'b1;
    start            = 1'b0;
    read_start_addr  = '0;
    read_end_addr    = '0;
    write_start_addr = '0;
    ld_en            = 1'b0;
    ld_addr          = '0;
    ld_data          = '0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_ovf0", overflow, 0);
    check("rst_en0", sram_en, 0);
    check("rst_we0", sram_we, 0);
    check("rst_addr0", sram_addr, 0);
    check("rst_wdata0", sram_wdata, 0);
    rst = 1'b0;

    poke(9'd0, 64'h00000001_00000002);
    poke(9'd1, 64'h00000003_00000004);
    run(9'd0, 9'd1, 9'd10, 0, 1'b0);
    check("single_mem10", mem[10], 64'h00000004_00000006);
    check("single_ovf", overflow, 0);

    poke(9'd20, 64'hFFFFFFFF_00000001);
    poke(9'd21, 64'h00000001_FFFFFFFF);
    run(9'd20, 9'd21, 9'd30, 0, 1'b0);
    check("wrap_mem30", mem[30], 64'h0);
    check("wrap_ovf", overflow, 1);
    repeat (3) @(negedge clk);
    check("wrap_ovf_sticky", overflow, 1);

    for (int i = 4; i <= 8; i++) begin
      poke(9'(i), {$urandom, $urandom});
    end
    run(9'd4, 9'd8, 9'd40, 0, 1'b0);

    run(9'd5, 9'd5, 9'd50, 0, 1'b0);
    run(9'd7, 9'd3, 9'd50, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      poke(9'(i), {$urandom, $urandom});
    end
    run(9'd0, 9'd3, 9'd511, 0, 1'b0);

    for (int i = 60; i < 64; i++) begin
      poke(9'(i), {$urandom, $urandom});
    end
    run(9'd60, 9'd63, 9'd70, 0, 1'b1);

    poke(9'd80, 64'hDEAD_BEEF_0BAD_F00D);
    run(9'd60, 9'd63, 9'd80, 4, 1'b0);
    check("abort_mem80", mem[80], 64'hDEAD_BEEF_0BAD_F00D);
    run(9'd60, 9'd63, 9'd80, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
